// File: rtl/spike_encoder_pkg.sv
// Shared types and constants for the rate-coded spike encoder.
// Holds the FSM encoding, default sizing and a counter-width helper.
package spike_encoder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_N_CH   = 8;
  localparam int DEF_VAL_W  = 4;
  localparam int DEF_WINDOW = 64;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spike_encoder_rate_channel.sv
// One spike channel: a modular phase accumulator whose carry-out is the spike.
// Over k steps the carry count equals floor(k*val / 2^VAL_W).
module rate_channel
  import spike_encoder_pkg::*;
#(
  parameter int VAL_W = DEF_VAL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step_en,
  input  logic [VAL_W-1:0] val,
  output logic             spike
);

  logic [VAL_W-1:0] acc_q, acc_d;
  logic             spike_q, spike_d;
  logic [VAL_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, val};
    acc_d   = acc_q;
    spike_d = spike_q;
    // Clear wins over stepping so a new window always starts from phase zero.
    if (clr) begin
      acc_d   = '0;
      spike_d = 1'b0;
    end else if (step_en) begin
      acc_d   = sum[VAL_W-1:0];
      spike_d = sum[VAL_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;

endmodule

// File: rtl/spike_encoder.sv
// Serial-load, fixed-window rate encoder feeding the neuron's spike inputs.
// Load handshake: a beat transfers on a rising edge where load_valid && load_ready.
module spike_encoder
  import spike_encoder_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int VAL_W  = DEF_VAL_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [VAL_W-1:0] load_data,
  input  logic             train_en,
  output logic [N_CH-1:0]  spikes,
  output logic             learn,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  localparam int CH_W = cnt_w(N_CH);
  localparam int ST_W = cnt_w(WINDOW);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [ST_W-1:0] LAST_STEP = ST_W'(WINDOW - 1);

  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
  logic [ST_W-1:0]  step_cnt_q, step_cnt_d;
  logic [VAL_W-1:0] val_q [N_CH];
  logic [VAL_W-1:0] val_d [N_CH];
  logic             train_lat_q, train_lat_d;
  logic             load_ready_q, load_ready_d;
  logic             learn_q, learn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             beat;
  logic             chan_clr;
  logic             chan_step;

  always_comb begin
    state_d      = state_q;
    ch_idx_d     = ch_idx_q;
    step_cnt_d   = step_cnt_q;
    val_d        = val_q;
    train_lat_d  = train_lat_q;
    load_ready_d = load_ready_q;
    learn_d      = learn_q;
    busy_d       = busy_q;
    done_d       = done_q;
    chan_clr     = 1'b0;
    chan_step    = 1'b0;
    beat         = load_valid && load_ready_q;

    case (state_q)
      ST_LOAD: begin
        if (beat) begin
          val_d[ch_idx_q] = load_data;
          if (ch_idx_q == LAST_CH) begin
            train_lat_d  = train_en;
            ch_idx_d     = '0;
            step_cnt_d   = '0;
            chan_clr     = 1'b1;
            load_ready_d = 1'b0;
            busy_d       = 1'b1;
            state_d      = ST_RUN;
          end else begin
            ch_idx_d = ch_idx_q + CH_W'(1);
          end
        end
      end

      ST_RUN: begin
        chan_step = 1'b1;
        learn_d   = train_lat_q;
        // The WINDOW-th step is computed on this edge; DONE then presents it.
        if (step_cnt_q == LAST_STEP) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          step_cnt_d = step_cnt_q + ST_W'(1);
        end
      end

      ST_DONE: begin
        chan_clr     = 1'b1;
        learn_d      = 1'b0;
        done_d       = 1'b0;
        busy_d       = 1'b0;
        load_ready_d = 1'b1;
        state_d      = ST_LOAD;
      end

      default: begin
        chan_clr     = 1'b1;
        learn_d      = 1'b0;
        done_d       = 1'b0;
        busy_d       = 1'b0;
        load_ready_d = 1'b1;
        ch_idx_d     = '0;
        state_d      = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      ch_idx_q     <= '0;
      step_cnt_q   <= '0;
      train_lat_q  <= 1'b0;
      load_ready_q <= 1'b1;
      learn_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < N_CH; i++) val_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ch_idx_q     <= ch_idx_d;
      step_cnt_q   <= step_cnt_d;
      train_lat_q  <= train_lat_d;
      load_ready_q <= load_ready_d;
      learn_q      <= learn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      val_q        <= val_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    rate_channel #(.VAL_W(VAL_W)) u_chan (
      .clk     (clk),
      .rst     (reset),
      .clr     (chan_clr),
      .step_en (chan_step),
      .val     (val_q[g]),
      .spike   (spikes[g])
    );
  end

  assign load_ready = load_ready_q;
  assign learn      = learn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: table vectors, random presentations
// and hand-written corner sequences, checked against a per-step rate model.
module tb_spike_encoder;
  import spike_encoder_pkg::*;

  localparam int N_CH   = 8;
  localparam int VAL_W  = 4;
  localparam int WINDOW = 64;

  typedef logic [VAL_W-1:0] vals_t [N_CH];
  typedef struct {
    vals_t v;
    logic  te;
    int    exp_cnt [N_CH];
    int    exp_learn;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [VAL_W-1:0] load_data;
  logic             train_en;
  logic [N_CH-1:0]  spikes;
  logic             learn;
  logic             busy;
  logic             done;
  state_e           dbg_state;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int cnt_obs [N_CH];
  int learn_cycles;
  logic [N_CH-1:0] exp_q [$];
  logic [N_CH-1:0] rec  [WINDOW];
  logic [N_CH-1:0] rec1 [WINDOW];
  vec_t tbl [4];

  spike_encoder #(.N_CH(N_CH), .VAL_W(VAL_W), .WINDOW(WINDOW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .train_en   (train_en),
    .spikes     (spikes),
    .learn      (learn),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Step k of a channel with value v spikes iff floor(k*v/2^VAL_W) advances.
  function automatic logic model_spike(input int k, input int v);
    return ((k * v) / (1 << VAL_W)) > (((k - 1) * v) / (1 << VAL_W));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [VAL_W-1:0] d, input logic te, input bit bubbles);
    bit acc;
    acc = 1'b0;
    if (bubbles) begin
      load_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    load_valid = 1'b1;
    load_data  = d;
    train_en   = te;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = load_ready;
      @(negedge clk);
    end
    if (!acc) check("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_all(input vals_t v, input logic te_last, input bit bubbles, input bit hold);
    for (int ch = 0; ch < N_CH; ch++)
      send_beat(v[ch], (ch == N_CH - 1) ? te_last : 1'b1, bubbles);
    if (!hold) load_valid = 1'b0;
    train_en = 1'b1;
  endtask

  // Called at the negedge right after the final beat was accepted.
  task automatic observe(input vals_t v, input logic te, input bit hold, input int stop_at);
    logic [N_CH-1:0] e;
    exp_q.delete();
    for (int k = 1; k <= WINDOW; k++) begin
      for (int ch = 0; ch < N_CH; ch++) e[ch] = model_spike(k, int'(v[ch]));
      exp_q.push_back(e);
    end
    for (int ch = 0; ch < N_CH; ch++) cnt_obs[ch] = 0;
    learn_cycles = 0;
    check("pre_step_spikes", 32'(spikes), 32'd0);
    check("pre_step_learn", 32'(learn), 32'd0);
    check("pre_step_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= WINDOW; k++) begin
      if (hold) load_data = VAL_W'($urandom_range(0, (1 << VAL_W) - 1));
      @(negedge clk);
      e = exp_q.pop_front();
      check("spikes_step", 32'(spikes), 32'(e));
      check("learn_step", 32'(learn), 32'(te));
      check("done_step", 32'(done), 32'(k == WINDOW));
      check("ready_run", 32'(load_ready), 32'd0);
      check("busy_run", 32'(busy), 32'd1);
      rec[k-1] = spikes;
      for (int ch = 0; ch < N_CH; ch++) cnt_obs[ch] += int'(spikes[ch]);
      learn_cycles += int'(learn);
      if (k == stop_at) return;
    end
    @(negedge clk);
    check("post_spikes", 32'(spikes), 32'd0);
    check("post_learn", 32'(learn), 32'd0);
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_ready", 32'(load_ready), 32'd1);
    for (int ch = 0; ch < N_CH; ch++)
      check("rate_count", 32'(cnt_obs[ch]), 32'((WINDOW * int'(v[ch])) / (1 << VAL_W)));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vals_t rv;
    int d0;

    tbl[0].v = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd12, 4'd15, 4'd15};
    tbl[0].te = 1'b1;
    tbl[0].exp_cnt = '{0, 4, 8, 16, 32, 48, 60, 60};
    tbl[0].exp_learn = 64;
    tbl[1].v = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd12, 4'd15, 4'd15};
    tbl[1].te = 1'b0;
    tbl[1].exp_cnt = '{0, 4, 8, 16, 32, 48, 60, 60};
    tbl[1].exp_learn = 0;
    tbl[2].v = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
    tbl[2].te = 1'b1;
    tbl[2].exp_cnt = '{32, 32, 32, 32, 32, 32, 32, 32};
    tbl[2].exp_learn = 64;
    tbl[3].v = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd14, 4'd6};
    tbl[3].te = 1'b1;
    tbl[3].exp_cnt = '{12, 20, 28, 36, 44, 52, 56, 24};
    tbl[3].exp_learn = 64;

    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    train_en   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(load_ready), 32'd1);
    check("reset_spikes", 32'(spikes), 32'd0);
    check("reset_learn", 32'(learn), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_LOAD));
    reset = 1'b0;
    @(negedge clk);

    // Table vectors; the last one holds load_valid through RUN/DONE.
    for (int i = 0; i < 4; i++) begin
      load_all(tbl[i].v, tbl[i].te, 1'b1, i == 3);
      observe(tbl[i].v, tbl[i].te, i == 3, 0);
      for (int ch = 0; ch < N_CH; ch++)
        check("table_count", 32'(cnt_obs[ch]), 32'(tbl[i].exp_cnt[ch]));
      check("table_learn_cycles", 32'(learn_cycles), 32'(tbl[i].exp_learn));
    end
    // load_valid is still high here, so the first LOAD edge takes this beat.
    load_all(tbl[0].v, 1'b1, 1'b0, 1'b0);
    observe(tbl[0].v, 1'b1, 1'b0, 0);

    // Random presentations.
    for (int n = 0; n < 8; n++) begin
      logic te;
      for (int ch = 0; ch < N_CH; ch++) rv[ch] = VAL_W'($urandom_range(0, (1 << VAL_W) - 1));
      te = 1'($urandom_range(0, 1));
      load_all(rv, te, 1'b1, 1'b0);
      observe(rv, te, 1'b0, 0);
    end

    // Reset in the middle of a window, then a discarded partial load.
    load_all(tbl[0].v, 1'b1, 1'b0, 1'b0);
    observe(tbl[0].v, 1'b1, 1'b0, 20);
    #1 reset = 1'b1;
    #1;
    check("mid_reset_spikes", 32'(spikes), 32'd0);
    check("mid_reset_learn", 32'(learn), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_ready", 32'(load_ready), 32'd1);
    for (int ch = 0; ch < 3; ch++) send_beat(4'd15, 1'b0, 1'b0);
    load_valid = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load_all(tbl[0].v, 1'b1, 1'b0, 1'b0);
    observe(tbl[0].v, 1'b1, 1'b0, 0);
    for (int ch = 0; ch < N_CH; ch++)
      check("reset_reload_count", 32'(cnt_obs[ch]), 32'(tbl[0].exp_cnt[ch]));

    // Back-to-back identical presentations with no idle cycles.
    for (int ch = 0; ch < N_CH; ch++) rv[ch] = VAL_W'($urandom_range(0, (1 << VAL_W) - 1));
    d0 = done_cnt;
    load_all(rv, 1'b1, 1'b0, 1'b0);
    observe(rv, 1'b1, 1'b0, 0);
    for (int k = 0; k < WINDOW; k++) rec1[k] = rec[k];
    load_all(rv, 1'b1, 1'b0, 1'b0);
    observe(rv, 1'b1, 1'b0, 0);
    for (int k = 0; k < WINDOW; k++) check("b2b_repeat", 32'(rec[k]), 32'(rec1[k]));
    check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
